// File: rtl/booth_mult_rr_sched.sv
// booth_mult_rr_sched: round-robin arbiter sharing one sequential radix-2 Booth multiplier among N_REQ requesters
module booth_mult_rr_sched #(
    parameter int N_REQ = 4,
    parameter int WIDTH = 8,
    parameter int ID_W  = $clog2(N_REQ)
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [N_REQ-1:0]         req_valid,
    output logic [N_REQ-1:0]         req_ready,
    input  logic [N_REQ*WIDTH-1:0]   num1_bus,
    input  logic [N_REQ*WIDTH-1:0]   num2_bus,
    output logic                     res_valid,
    input  logic                     res_ready,
    output logic [2*WIDTH-1:0]       res_data,
    output logic [ID_W-1:0]          res_id,
    output logic                     busy
);
    localparam int CNT_W = $clog2(WIDTH + 1);
    typedef enum logic [1:0] {IDLE, MUL, DONE} state_t;
    state_t state, state_nx;
    logic [ID_W-1:0] last_grant, grant, idx, id;
    logic grant_any, accept, last_step, q_1;
    logic [WIDTH-1:0] op1, op2, q, q_nx;
    logic signed [WIDTH:0] a, m, sum, a_nx;
    logic [CNT_W-1:0] cnt;
    // Iterate farthest-first so the nearest valid requester after last_grant wins.
    always_comb begin
        grant_any = 1'b0;
        grant = '0;
        idx = '0;
        for (int k = N_REQ; k >= 1; k--) begin
            idx = ID_W'((int'(last_grant) + k) % N_REQ);
            if (req_valid[idx]) begin
                grant_any = 1'b1;
                grant = idx;
            end
        end
    end
    always_comb begin
        op1 = '0;
        op2 = '0;
        for (int i = 0; i < N_REQ; i++)
            if (grant == ID_W'(i)) begin
                op1 = num1_bus[i*WIDTH +: WIDTH];
                op2 = num2_bus[i*WIDTH +: WIDTH];
            end
    end
    assign accept    = state == IDLE && rst_n && grant_any;
    assign req_ready = accept ? (N_REQ'(1) << grant) : '0;
    assign busy      = state != IDLE;
    assign sum       = (q[0] == q_1) ? a : (q[0] ? a - m : a + m);
    assign a_nx      = {sum[WIDTH], sum[WIDTH:1]};
    assign q_nx      = {sum[0], q[WIDTH-1:1]};
    assign last_step = cnt == CNT_W'(WIDTH - 1);
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    state_nx = accept ? MUL : IDLE;
            MUL:     state_nx = last_step ? DONE : MUL;
            DONE:    state_nx = res_ready ? IDLE : DONE;
            default: state_nx = IDLE;
        endcase
    end
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) state <= IDLE;
        else state <= state_nx;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_grant <= ID_W'(N_REQ - 1);
            a <= '0;
            m <= '0;
            q <= '0;
            q_1 <= 1'b0;
            cnt <= '0;
            id <= '0;
            res_valid <= 1'b0;
            res_data <= '0;
            res_id <= '0;
        end else if (accept) begin
            last_grant <= grant;
            m <= {op1[WIDTH-1], op1};
            q <= op2;
            a <= '0;
            q_1 <= 1'b0;
            cnt <= '0;
            id <= grant;
        end else if (state == MUL) begin
            a <= a_nx;
            q <= q_nx;
            q_1 <= q[0];
            cnt <= cnt + 1'b1;
            if (last_step) begin
                res_data <= {a_nx[WIDTH-1:0], q_nx};
                res_id <= id;
                res_valid <= 1'b1;
            end
        end else if (state == DONE && res_ready) begin
            res_valid <= 1'b0;
        end
    end
endmodule

// File: tb/tb_booth_mult_rr_sched.sv
// tb_booth_mult_rr_sched: random requesters and consumer checked against a transaction-level scheduler model
module tb_booth_mult_rr_sched;
    localparam int N = 4;
    localparam int W = 8;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic [N-1:0] req_valid, req_ready;
    logic [N*W-1:0] num1_bus, num2_bus;
    logic res_valid, res_ready, busy;
    logic [2*W-1:0] res_data;
    logic [1:0] res_id;
    booth_mult_rr_sched #(.N_REQ(N), .WIDTH(W)) dut (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
        .num1_bus(num1_bus), .num2_bus(num2_bus), .res_valid(res_valid),
        .res_ready(res_ready), .res_data(res_data), .res_id(res_id), .busy(busy)
    );
    always #5 clk = ~clk;
    int checks = 0;
    int errors = 0;
    logic pend [N];
    logic signed [W-1:0] n1 [N];
    logic signed [W-1:0] n2 [N];
    int mt = -1;
    int ptr = N - 1;
    int mid = 0;
    int nid = 0;
    int ops = 0;
    int resets = 0;
    int g;
    logic [2*W-1:0] mres = '0;
    logic signed [2*W-1:0] nprod = '0;
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h exp %0h", tag, got, exp);
        end
    endtask
    function automatic int pick();
        for (int k = 1; k <= N; k++)
            if (pend[(ptr + k) % N]) return (ptr + k) % N;
        return -1;
    endfunction
    function automatic logic [W-1:0] rand_op();
        case ($urandom_range(0, 5))
            0: return {1'b1, {(W-1){1'b0}}};
            1: return {1'b0, {(W-1){1'b1}}};
            2: return '0;
            3: return '1;
            default: return W'($urandom);
        endcase
    endfunction
    task automatic drive();
        for (int i = 0; i < N; i++) begin
            req_valid[i] = pend[i];
            num1_bus[i*W +: W] = n1[i];
            num2_bus[i*W +: W] = n2[i];
        end
    endtask
    task automatic check_zero(input string tag);
        check({tag, "_ready"}, 32'(req_ready), 32'd0);
        check({tag, "_busy"}, 32'(busy), 32'd0);
        check({tag, "_valid"}, 32'(res_valid), 32'd0);
        check({tag, "_data"}, 32'(res_data), 32'd0);
        check({tag, "_id"}, 32'(res_id), 32'd0);
    endtask
    initial begin
        res_ready = 1'b0;
        n1[0] = 10;  n2[0] = -9;
        n1[1] = -3;  n2[1] = -7;
        n1[2] = -3;  n2[2] = 10;
        n1[3] = 7;   n2[3] = 3;
        for (int i = 0; i < N; i++) pend[i] = 1'b1;
        drive();
        #1;
        check_zero("reset");
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            rst_n = 1'b1;
            if (c > 0)
                for (int i = 0; i < N; i++)
                    if (!pend[i] && $urandom_range(0, 3) == 0) begin
                        pend[i] = 1'b1;
                        n1[i] = rand_op();
                        n2[i] = rand_op();
                    end
            res_ready = $urandom_range(0, 9) < 6;
            drive();
            #1;
            g = pick();
            check("req_ready", 32'(req_ready), (mt < 0 && g >= 0) ? 32'(1) << g : 32'd0);
            check("busy", 32'(busy), 32'(mt >= 0));
            check("res_valid", 32'(res_valid), 32'(mt >= W));
            check("res_data", 32'(res_data), 32'(mres));
            check("res_id", 32'(res_id), 32'(mid));
            if (resets < 2 && c > 500 * (resets + 1) && mt == 3) begin
                rst_n = 1'b0;
                #1;
                check_zero("midrst");
                mt = -1;
                ptr = N - 1;
                mres = '0;
                mid = 0;
                resets++;
                continue;
            end
            if (mt < 0) begin
                if (g >= 0) begin
                    ptr = g;
                    nprod = n1[g] * n2[g];
                    nid = g;
                    pend[g] = 1'b0;
                    mt = 0;
                end
            end else if (mt < W) begin
                mt++;
                if (mt == W) begin
                    mres = nprod;
                    mid = nid;
                    ops++;
                end
            end else if (res_ready) begin
                mt = -1;
            end
        end
        check("ops_done", 32'(ops > 50), 32'd1);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
